// File: rtl/ones_count_pkg.sv
// Shared types and arithmetic helpers for the multi-lane ones counter.
// The helpers work at fixed maximum widths. Callers size the arguments and results with casts.
package ones_count_pkg;

    localparam int MAX_X_W   = 64;
    localparam int MAX_ACC_W = 32;

    typedef enum logic {
        MODE_BEAT  = 1'b0,
        MODE_FRAME = 1'b1
    } mode_e;

    typedef struct packed {
        logic z;
        logic sat;
    } lane_flags_t;

    function automatic logic [MAX_ACC_W-1:0] popcount(input logic [MAX_X_W-1:0] x);
        logic [MAX_ACC_W-1:0] c;
        c = '0;
        for (int k = 0; k < MAX_X_W; k++) c += MAX_ACC_W'(x[k]);
        return c;
    endfunction

    // The width argument w gives the clamp limit, which is 2^w-1.
    function automatic logic [MAX_ACC_W-1:0] sat_add(input logic [MAX_ACC_W-1:0] a,
                                                     input logic [MAX_ACC_W-1:0] b,
                                                     input int w);
        logic [MAX_ACC_W:0] s, lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((MAX_ACC_W+1)'(1) << w) - (MAX_ACC_W+1)'(1);
        return (s > lim) ? lim[MAX_ACC_W-1:0] : s[MAX_ACC_W-1:0];
    endfunction

    function automatic logic add_clamps(input logic [MAX_ACC_W-1:0] a,
                                        input logic [MAX_ACC_W-1:0] b,
                                        input int w);
        logic [MAX_ACC_W:0] s, lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((MAX_ACC_W+1)'(1) << w) - (MAX_ACC_W+1)'(1);
        return s > lim;
    endfunction

endpackage

// File: rtl/ones_count_fifo2.sv
// Generic 2-entry in-order valid/ready buffer.
// in_ready comes from the registered count only, so it has no combinational path from out_ready.
module ones_count_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0][W-1:0] mem;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        cnt;
    logic              push, pop;

    assign in_ready  = (cnt != 2'd2);
    assign out_valid = (cnt != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ones_count_pipe.sv
// This block counts the ones in each of NUM_CH lanes. It can report one result per beat,
// or one saturating sum for each frame that in_last closes. Results pass through a 2-entry buffer.
import ones_count_pkg::*;

module ones_count_pipe #(
    parameter int X_W    = 4,
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 8,
    parameter int THRESH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*X_W-1:0]   in_x,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*ACC_W-1:0] out_y,
    output logic [NUM_CH-1:0]       out_z,
    output logic [NUM_CH-1:0]       out_sat
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    typedef struct packed {
        logic [ACC_W-1:0] y;
        lane_flags_t      f;
    } lane_res_t;

    logic [0:0]                    state_r;
    mode_e                         mode_r, cur_mode;
    logic                          fifo_ready, accept, closes, push;
    logic [NUM_CH-1:0][ACC_W-1:0]  acc_r, sum;
    logic [NUM_CH-1:0]             sat_r, hit;
    lane_res_t [NUM_CH-1:0]        push_data, pop_data;

    // The mode input is sampled only while idle. Inside a frame the latched mode holds.
    assign cur_mode = (state_r == ST_IDLE) ? mode_e'(mode) : mode_r;
    assign in_ready = fifo_ready;
    assign accept   = in_valid & fifo_ready;
    assign closes   = (cur_mode == MODE_BEAT) | in_last;
    assign push     = accept & closes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_BEAT;
        end else if (accept) begin
            if (closes) begin
                state_r <= ST_IDLE;
            end else begin
                if (state_r == ST_IDLE) mode_r <= cur_mode;
                state_r <= ST_FRAME;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        logic [ACC_W-1:0] pop;

        assign pop    = ACC_W'(popcount(MAX_X_W'(in_x[i*X_W +: X_W])));
        assign sum[i] = ACC_W'(sat_add(MAX_ACC_W'(acc_r[i]), MAX_ACC_W'(pop), ACC_W));
        assign hit[i] = sat_r[i] | add_clamps(MAX_ACC_W'(acc_r[i]), MAX_ACC_W'(pop), ACC_W);

        assign push_data[i].y     = sum[i];
        assign push_data[i].f.z   = (sum[i] >= ACC_W'(THRESH));
        assign push_data[i].f.sat = (cur_mode == MODE_FRAME) & hit[i];

        // The accumulator stays at zero while idle, so a beat-mode result equals the plain popcount.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_r[i] <= '0;
                sat_r[i] <= 1'b0;
            end else if (accept) begin
                acc_r[i] <= closes ? '0 : sum[i];
                sat_r[i] <= closes ? 1'b0 : hit[i];
            end
        end

        assign out_y[i*ACC_W +: ACC_W] = pop_data[i].y;
        assign out_z[i]                = pop_data[i].f.z;
        assign out_sat[i]              = pop_data[i].f.sat;
    end

    ones_count_fifo2 #(.W($bits(push_data))) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push),
        .in_ready  (fifo_ready),
        .in_data   (push_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pop_data)
    );

endmodule
